// File: rtl/sym_dec.sv
// Receive-side symbol decoder: hard-decides one bit per OFDM symbol from two bin magnitudes,
// then acquires the preamble, hunts the SFD, parses the PHR length and writes payload bytes.
module sym_dec #(
    parameter int unsigned      WIDTH       = 10,
    parameter logic [WIDTH-1:0] THRESH      = 10'd64,
    parameter int unsigned      PRE_MIN     = 8,
    parameter logic [7:0]       SFD         = 8'hA7,
    parameter int unsigned      SFD_TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_sym_valid,
    input  logic [WIDTH-1:0] i_bin1_mag,
    input  logic [WIDTH-1:0] i_bin2_mag,
    output logic             o_buf_w_en,
    output logic [6:0]       o_buf_w_addr,
    output logic [7:0]       o_buf_byte,
    output logic [6:0]       o_len,
    output logic [2:0]       o_ev,
    output logic             o_ev_sig,
    output logic             o_active,
    output logic             o_sfd
);

    localparam int ALT_W = $clog2(PRE_MIN + 1);
    localparam int TO_W  = $clog2(SFD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD_HUNT,
        S_PHR,
        S_PAYLOAD
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE    = 3'd0,
        EV_STARTED = 3'd1,
        EV_SFD     = 3'd2,
        EV_PHR     = 3'd3,
        EV_BYTE    = 3'd4,
        EV_END     = 3'd5,
        EV_ERROR   = 3'd6
    } event_e;

    state_e           state_q;
    event_e           ev_q;
    logic             evSig_q;
    logic [7:0]       sr_q;
    logic [2:0]       bitCnt_q;
    logic [ALT_W-1:0] altCnt_q;
    logic             prevBit_q;
    logic [TO_W-1:0]  toCnt_q;
    logic [6:0]       idx_q;
    logic [6:0]       len_q;
    logic             wEn_q;
    logic [6:0]       wAddr_q;
    logic [7:0]       byte_q;
    logic             active_q;
    logic             sfd_q;

    logic [WIDTH-1:0] maxMag;
    logic             carrier;
    logic             symBit;
    logic [7:0]       srNext;
    logic [ALT_W-1:0] altNext;
    logic [TO_W-1:0]  toNext;
    logic             errNow;

    assign maxMag  = (i_bin1_mag > i_bin2_mag) ? i_bin1_mag : i_bin2_mag;
    assign carrier = (maxMag >= THRESH);
    assign symBit  = (i_bin1_mag > i_bin2_mag);
    assign srNext  = {symBit, sr_q[7:1]};
    assign altNext = altCnt_q + ALT_W'(1);
    assign toNext  = toCnt_q + TO_W'(1);

    // Every abort condition gathered here so the FSM handles ERROR in one place.
    always_comb begin
        errNow = 1'b0;
        if (i_sym_valid) begin
            case (state_q)
                S_SFD_HUNT: errNow = !carrier || (srNext != SFD && toNext == TO_W'(SFD_TIMEOUT));
                S_PHR:      errNow = !carrier ||
                                     (bitCnt_q == 3'd7 && (srNext[7] || srNext[6:0] == 7'd0));
                S_PAYLOAD:  errNow = !carrier;
                default:    errNow = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ev_q      <= EV_NONE;
            evSig_q   <= 1'b0;
            sr_q      <= 8'd0;
            bitCnt_q  <= 3'd0;
            altCnt_q  <= '0;
            prevBit_q <= 1'b0;
            toCnt_q   <= '0;
            idx_q     <= 7'd0;
            len_q     <= 7'd0;
            wEn_q     <= 1'b0;
            wAddr_q   <= 7'd0;
            byte_q    <= 8'd0;
            active_q  <= 1'b0;
            sfd_q     <= 1'b0;
        end else begin
            ev_q    <= EV_NONE;
            evSig_q <= 1'b0;
            wEn_q   <= 1'b0;
            if (i_sym_valid) begin
                sr_q <= srNext;
                if (errNow) begin
                    state_q  <= S_IDLE;
                    ev_q     <= EV_ERROR;
                    evSig_q  <= 1'b1;
                    active_q <= 1'b0;
                    sfd_q    <= 1'b0;
                end else begin
                    case (state_q)
                        S_IDLE: begin
                            if (carrier) begin
                                state_q   <= S_PREAMBLE;
                                altCnt_q  <= ALT_W'(1);
                                prevBit_q <= symBit;
                            end
                        end
                        S_PREAMBLE: begin
                            if (!carrier) begin
                                state_q <= S_IDLE;
                            end else begin
                                prevBit_q <= symBit;
                                if (symBit == prevBit_q) begin
                                    altCnt_q <= ALT_W'(1);
                                end else if (altNext == ALT_W'(PRE_MIN)) begin
                                    state_q  <= S_SFD_HUNT;
                                    ev_q     <= EV_STARTED;
                                    evSig_q  <= 1'b1;
                                    active_q <= 1'b1;
                                    toCnt_q  <= '0;
                                    altCnt_q <= '0;
                                end else begin
                                    altCnt_q <= altNext;
                                end
                            end
                        end
                        S_SFD_HUNT: begin
                            // The match window spans preamble bits too, since sr shifts on every symbol.
                            if (srNext == SFD) begin
                                state_q  <= S_PHR;
                                ev_q     <= EV_SFD;
                                evSig_q  <= 1'b1;
                                sfd_q    <= 1'b1;
                                bitCnt_q <= 3'd0;
                            end else begin
                                toCnt_q <= toNext;
                            end
                        end
                        S_PHR: begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                state_q <= S_PAYLOAD;
                                len_q   <= srNext[6:0];
                                ev_q    <= EV_PHR;
                                evSig_q <= 1'b1;
                                idx_q   <= 7'd0;
                            end
                        end
                        S_PAYLOAD: begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                            if (bitCnt_q == 3'd7) begin
                                wEn_q   <= 1'b1;
                                wAddr_q <= idx_q;
                                byte_q  <= srNext;
                                evSig_q <= 1'b1;
                                if (idx_q == len_q - 7'd1) begin
                                    state_q  <= S_IDLE;
                                    ev_q     <= EV_END;
                                    active_q <= 1'b0;
                                    sfd_q    <= 1'b0;
                                end else begin
                                    ev_q  <= EV_BYTE;
                                    idx_q <= idx_q + 7'd1;
                                end
                            end
                        end
                        default: state_q <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign o_ev         = ev_q;
    assign o_ev_sig     = evSig_q;
    assign o_buf_w_en   = wEn_q;
    assign o_buf_w_addr = wAddr_q;
    assign o_buf_byte   = byte_q;
    assign o_len        = len_q;
    assign o_active     = active_q;
    assign o_sfd        = sfd_q;

endmodule
